// File: rtl/led_pkg.sv
// Shared constants for the LED output stage: channel count, default PWM/decay
// settings and the UD assignment-delay hook used by the LED blocks.
`ifndef UD
`define UD
`endif

package led_pkg;

    localparam int LED_NUM        = 8;
    localparam int PWM_BITS_DEF   = 8;
    localparam int DECAY_DIV_DEF  = 500000;
    localparam int DECAY_STEP_DEF = 16;

endpackage : led_pkg

// File: rtl/led_fade_chan.sv
// One LED channel: brightness register with saturating decay and PWM compare.
// LED_FADE_GAMMA_EN adds a registered square-law compare value (one extra cycle).
module led_fade_chan
    import led_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int DECAY_STEP = DECAY_STEP_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en_i,
    input  logic                led_i,
    input  logic                decay_tick_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DUTY_ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic [PWM_BITS-1:0] cmp_s;
    logic                led_q;
    logic                led_d;

    // Next brightness: bypass load, instant full-on, saturating decay, hold.
    always_comb begin
        duty_d = duty_q;
        if (!en_i) begin
            duty_d = led_i ? DUTY_MAX : DUTY_ZERO;
        end else if (led_i) begin
            duty_d = DUTY_MAX;
        end else if (decay_tick_i) begin
            duty_d = (duty_q > STEP) ? (duty_q - STEP) : DUTY_ZERO;
        end else begin
            duty_d = duty_q;
        end
    end

`ifdef LED_FADE_GAMMA_EN
    logic [PWM_BITS:0]   duty_inc_s;
    logic [2*PWM_BITS:0] prod_s;
    logic [PWM_BITS-1:0] gamma_q;
    logic [PWM_BITS-1:0] gamma_d;

    // d*(d+1)>>PWM_BITS keeps both endpoints exact (0->0, MAX->MAX).
    always_comb begin
        duty_inc_s = {1'b0, duty_q} + {{PWM_BITS{1'b0}}, 1'b1};
        prod_s     = {{(PWM_BITS+1){1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_inc_s};
        gamma_d    = PWM_BITS'(prod_s >> PWM_BITS);
    end

    // Perceptual compare pipeline register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            gamma_q <= `UD DUTY_ZERO;
        end else begin
            gamma_q <= `UD gamma_d;
        end
    end

    assign cmp_s = gamma_q;
`else
    assign cmp_s = duty_q;
`endif

    // Bypass mirrors the input; otherwise high while compare exceeds the count.
    always_comb begin
        led_d = led_i;
        if (en_i) begin
            led_d = (cmp_s > pwm_cnt_i);
        end else begin
            led_d = led_i;
        end
    end

    // Channel state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            duty_q <= `UD DUTY_ZERO;
            led_q  <= `UD 1'b0;
        end else begin
            duty_q <= `UD duty_d;
            led_q  <= `UD led_d;
        end
    end

    assign led_o = led_q;

endmodule : led_fade_chan

// File: rtl/led_fade_pwm.sv
// LED fade/PWM output stage: shared PWM counter and decay divider feeding one
// led_fade_chan per LED. Optional square-law curve via LED_FADE_GAMMA_EN.
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int DECAY_DIV  = DECAY_DIV_DEF,
    parameter int DECAY_STEP = DECAY_STEP_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [LED_NUM-1:0] led_in,
    output logic [LED_NUM-1:0] led_out,
    output logic               pwm_wrap
);

    localparam int DIV_W = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;

    // The counter stops one short of all-ones so MAX duty is solid on.
    localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'((2 ** PWM_BITS) - 2);
    localparam logic [PWM_BITS-1:0] PWM_ZERO  = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(DECAY_DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]    DIV_ONE   = DIV_W'(1);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic [DIV_W-1:0]    decay_cnt_q;
    logic [DIV_W-1:0]    decay_cnt_d;
    logic                pwm_wrap_q;
    logic                pwm_wrap_d;
    logic                decay_tick_s;

    // Free-running counters, independent of en and led_in.
    always_comb begin
        pwm_cnt_d    = pwm_cnt_q;
        pwm_wrap_d   = 1'b0;
        decay_cnt_d  = decay_cnt_q;
        decay_tick_s = 1'b0;
        if (pwm_cnt_q == PWM_LAST) begin
            pwm_cnt_d  = PWM_ZERO;
            pwm_wrap_d = 1'b1;
        end else begin
            pwm_cnt_d  = pwm_cnt_q + PWM_ONE;
            pwm_wrap_d = 1'b0;
        end
        if (decay_cnt_q == DIV_LAST) begin
            decay_cnt_d  = DIV_ZERO;
            decay_tick_s = 1'b1;
        end else begin
            decay_cnt_d  = decay_cnt_q + DIV_ONE;
            decay_tick_s = 1'b0;
        end
    end

    // Counter and wrap-pulse registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pwm_cnt_q   <= `UD PWM_ZERO;
            decay_cnt_q <= `UD DIV_ZERO;
            pwm_wrap_q  <= `UD 1'b0;
        end else begin
            pwm_cnt_q   <= `UD pwm_cnt_d;
            decay_cnt_q <= `UD decay_cnt_d;
            pwm_wrap_q  <= `UD pwm_wrap_d;
        end
    end

    assign pwm_wrap = pwm_wrap_q;

    for (genvar i = 0; i < LED_NUM; i++) begin : g_chan
        led_fade_chan #(
            .PWM_BITS   (PWM_BITS),
            .DECAY_STEP (DECAY_STEP)
        ) u_chan (
            .clk          (clk),
            .rstn         (rstn),
            .en_i         (en),
            .led_i        (led_in[i]),
            .decay_tick_i (decay_tick_s),
            .pwm_cnt_i    (pwm_cnt_q),
            .led_o        (led_out[i])
        );
    end

endmodule : led_fade_pwm

// File: tb/tb_led_fade_pwm.sv
// Directed self-checking bench for led_fade_pwm (linear or LED_FADE_GAMMA_EN build).
module tb_led_fade_pwm;

    localparam int PB = 8;
    localparam int DD = 4;
    localparam int DS = 64;

`ifdef LED_FADE_GAMMA_EN
    localparam int LAT  = 3;
    localparam int G255 = 255;
    localparam int G191 = 143;
    localparam int G127 = 63;
    localparam int G63  = 15;
`else
    localparam int LAT  = 2;
    localparam int G255 = 255;
    localparam int G191 = 191;
    localparam int G127 = 127;
    localparam int G63  = 63;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic [7:0] led_in;
    logic [7:0] led_out;
    logic       pwm_wrap;
    logic [7:0] led_out_slow;
    logic       pwm_wrap_slow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_fade_pwm #(.PWM_BITS(PB), .DECAY_DIV(DD), .DECAY_STEP(DS)) dut (
        .clk(clk), .rstn(rstn), .en(en), .led_in(led_in),
        .led_out(led_out), .pwm_wrap(pwm_wrap)
    );

    // Slow-decay instance so a single duty level lasts several PWM periods.
    led_fade_pwm #(.PWM_BITS(PB), .DECAY_DIV(300), .DECAY_STEP(DS)) dut_slow (
        .clk(clk), .rstn(rstn), .en(en), .led_in(led_in),
        .led_out(led_out_slow), .pwm_wrap(pwm_wrap_slow)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic [7:0] li, input logic e);
        rstn   = 1'b0;
        led_in = li;
        en     = e;
        repeat (3) step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        int e;
        int first;
        int second;
        rstn = 1'b0; led_in = 8'hFF; en = 1'b1;
        repeat (3) step();
        checks++;
        if (led_out !== 8'h00) begin errors++; $display("FAIL reset_led_out got %h expected 00", led_out); end
        checks++;
        if (pwm_wrap !== 1'b0) begin errors++; $display("FAIL reset_pwm_wrap got %b expected 0", pwm_wrap); end
        checks++;
        if (led_out_slow !== 8'h00) begin errors++; $display("FAIL reset_led_out_slow got %h expected 00", led_out_slow); end
        rstn  = 1'b1;
        first = 0;
        for (int k = 1; k <= 300 && first == 0; k++) begin
            step();
            if (k == LAT) begin
                checks++;
                if (led_out !== 8'hFF) begin errors++; $display("FAIL reset_release_on got %h expected ff", led_out); end
            end
            if (pwm_wrap === 1'b1) first = k;
        end
        checks++;
        if (first != 255) begin errors++; $display("FAIL first_wrap got %0d expected 255", first); end
        e = first;
        step(); e++;
        checks++;
        if (pwm_wrap !== 1'b0) begin errors++; $display("FAIL wrap_width got %b expected 0", pwm_wrap); end
        second = 0;
        for (int k = 0; k < 300 && second == 0; k++) begin
            step(); e++;
            if (pwm_wrap === 1'b1) second = e;
        end
        checks++;
        if (second != 510) begin errors++; $display("FAIL second_wrap got %0d expected 510", second); end
    endtask

    task automatic test_full_on();
        logic [7:0] exp;
        apply_reset(8'h00, 1'b1);
        for (int k = 1; k <= 600; k++) begin
            led_in = 8'h01;
            step();
            exp = (k >= LAT) ? 8'h01 : 8'h00;
            checks++;
            if (led_out !== exp) begin errors++; $display("FAIL full_on k=%0d got %h expected %h", k, led_out, exp); end
        end
    endtask

    // Drop at edge 252; ticks at 256/260/264/268 step 255->191->127->63->0.
    task automatic test_decay();
        logic [7:0] exp;
        apply_reset(8'h00, 1'b1);
        for (int k = 1; k <= 300; k++) begin
            led_in = (k <= 252) ? 8'h01 : 8'h00;
            step();
            exp = (k >= LAT && k <= 266 + LAT) ? 8'h01 : 8'h00;
            checks++;
            if (led_out !== exp) begin errors++; $display("FAIL decay k=%0d got %h expected %h", k, led_out, exp); end
        end
    endtask

    // Duty 127 from edge 144; led_in re-asserted on tick edge 148 must restore 255.
    task automatic test_collision();
        apply_reset(8'h00, 1'b1);
        for (int k = 1; k <= 170; k++) begin
            led_in = (k <= 136 || k == 148) ? 8'h01 : 8'h00;
            step();
            if (k == 146 + LAT) begin
                checks++;
                if (led_out !== 8'h00) begin errors++; $display("FAIL collision_pre k=%0d got %h expected 00", k, led_out); end
            end
            if (k >= 147 + LAT && k <= 150 + LAT) begin
                checks++;
                if (led_out !== 8'h01) begin errors++; $display("FAIL collision k=%0d got %h expected 01", k, led_out); end
            end
        end
    endtask

    task automatic test_reset_mid_fade();
        apply_reset(8'h00, 1'b1);
        for (int k = 1; k <= 520; k++) begin
            led_in = (k <= 252) ? 8'h01 : 8'h00;
            rstn   = (k == 262) ? 1'b0 : 1'b1;
            step();
            if (k == 261) begin
                checks++;
                if (led_out !== 8'h01) begin errors++; $display("FAIL mid_fade_pre got %h expected 01", led_out); end
            end
            if (k >= 262) begin
                checks++;
                if (led_out !== 8'h00) begin errors++; $display("FAIL mid_fade_off k=%0d got %h expected 00", k, led_out); end
                checks++;
                if (pwm_wrap !== (k == 517)) begin errors++; $display("FAIL mid_fade_wrap k=%0d got %b expected %b", k, pwm_wrap, (k == 517)); end
            end
        end
    endtask

    task automatic test_bypass();
        logic [7:0] exp;
        apply_reset(8'h00, 1'b0);
        for (int k = 1; k <= 260; k++) begin
            en     = (k <= 5) ? 1'b0 : 1'b1;
            led_in = (k == 1) ? 8'h01 : ((k == 2) ? 8'h02 : 8'h04);
            step();
            exp = (k == 1) ? 8'h01 : ((k == 2) ? 8'h02 : 8'h04);
            checks++;
            if (led_out !== exp) begin errors++; $display("FAIL bypass k=%0d got %h expected %h", k, led_out, exp); end
            if (k == 255) begin
                checks++;
                if (pwm_wrap !== 1'b1) begin errors++; $display("FAIL bypass_wrap got %b expected 1", pwm_wrap); end
            end
        end
    endtask

    // Slow instance: duty 255/191/127/63 each held 300 edges; count highs per 255 cycles.
    task automatic test_pwm_duty();
        int c255;
        int c191;
        int c127;
        int c63;
        c255 = 0; c191 = 0; c127 = 0; c63 = 0;
        apply_reset(8'h00, 1'b1);
        for (int k = 1; k <= 1170; k++) begin
            led_in = (k == 1) ? 8'h01 : 8'h00;
            step();
            if (k >= 10  && k <= 264)  c255 += int'(led_out_slow[0]);
            if (k >= 310 && k <= 564)  c191 += int'(led_out_slow[0]);
            if (k >= 610 && k <= 864)  c127 += int'(led_out_slow[0]);
            if (k >= 910 && k <= 1164) c63  += int'(led_out_slow[0]);
        end
        checks++;
        if (c255 != G255) begin errors++; $display("FAIL duty255_highs got %0d expected %0d", c255, G255); end
        checks++;
        if (c191 != G191) begin errors++; $display("FAIL duty191_highs got %0d expected %0d", c191, G191); end
        checks++;
        if (c127 != G127) begin errors++; $display("FAIL duty127_highs got %0d expected %0d", c127, G127); end
        checks++;
        if (c63 != G63) begin errors++; $display("FAIL duty63_highs got %0d expected %0d", c63, G63); end
    endtask

    initial begin
        rstn   = 1'b0;
        en     = 1'b1;
        led_in = 8'h00;
        test_reset();
        test_full_on();
        test_decay();
        test_collision();
        test_reset_mid_fade();
        test_bypass();
        test_pwm_duty();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_led_fade_pwm
